// File: rtl/ita_tile_accumulator_if.sv
// Beat/handshake bundle between ita_controller, ita_tile_accumulator and the requantizer.
// master: the side that drives beats and consumes the output FIFO.
// slave : the accumulator itself.
interface ita_tile_accumulator_if #(
    parameter int N  = 16,
    parameter int WO = 26
);
    logic              clear_i;
    logic              calc_en_i;
    logic              first_inner_tile_i;
    logic              last_inner_tile_i;
    logic [N-1:0]      lane_en_i;
    logic [N*WO-1:0]   psum_i;
    logic              oup_valid_o;
    logic              oup_ready_i;
    logic [N*WO-1:0]   oup_data_o;
    logic              tile_done_o;
    logic              overflow_o;

    modport master (
        output clear_i, calc_en_i, first_inner_tile_i, last_inner_tile_i,
               lane_en_i, psum_i, oup_ready_i,
        input  oup_valid_o, oup_data_o, tile_done_o, overflow_o
    );

    modport slave (
        input  clear_i, calc_en_i, first_inner_tile_i, last_inner_tile_i,
               lane_en_i, psum_i, oup_ready_i,
        output oup_valid_o, oup_data_o, tile_done_o, overflow_o
    );
endinterface

// File: rtl/ita_tile_accumulator.sv
// Tile accumulator: sums N-lane partial sums of one output tile over the inner
// tiles, and after the last inner tile pushes each finished beat into a small
// output FIFO drained with a valid/ready handshake.
module ita_tile_accumulator #(
    parameter int N          = 16,
    parameter int M          = 64,
    parameter int WO         = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ita_tile_accumulator_if.slave  bus
);
    localparam int DEPTH = M * M / N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    // Clamp a WO+1 bit sum into the WO-bit signed range.
    function automatic logic signed [WO-1:0] sat_wo(input logic signed [WO:0] x);
        if (x[WO] != x[WO-1]) begin
            sat_wo = x[WO] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
        end else begin
            sat_wo = x[WO-1:0];
        end
    endfunction

    logic [N*WO-1:0]         r_acc [DEPTH];
    logic [N*WO-1:0]         r_fifo [FIFO_DEPTH];
    logic [AW-1:0]           r_addr;
    logic [FW-1:0]           r_wptr;
    logic [FW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic                    r_overflow;
    logic                    r_tile_done;

    logic signed [WO-1:0]    w_base [N];
    logic signed [WO-1:0]    w_psum [N];
    logic signed [WO:0]      w_wide [N];
    logic signed [WO-1:0]    w_sum  [N];
    logic [N*WO-1:0]         w_sum_vec;
    logic [N*WO-1:0]         w_emit_vec;
    logic                    w_beat;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_push_ok;
    logic                    w_last_addr;

    // A beat is consumed only when clear does not override it.
    assign w_beat      = bus.calc_en_i && !bus.clear_i;
    assign w_push      = w_beat && bus.last_inner_tile_i;
    assign w_pop       = (r_count != '0) && bus.oup_ready_i;
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    // A full FIFO still takes a new beat when its head leaves in the same cycle.
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_last_addr = (r_addr == AW'(DEPTH - 1));

    // Per-lane saturating accumulate; first inner tile overwrites instead of adding.
    always_comb begin
        w_sum_vec  = '0;
        w_emit_vec = '0;
        for (int i = 0; i < N; i++) begin
            w_psum[i] = bus.psum_i[i*WO +: WO];
            w_base[i] = bus.first_inner_tile_i ? '0 : r_acc[r_addr][i*WO +: WO];
            w_wide[i] = {w_base[i][WO-1], w_base[i]} + {w_psum[i][WO-1], w_psum[i]};
            w_sum[i]  = sat_wo(w_wide[i]);
            w_sum_vec[i*WO +: WO] = w_sum[i];
            if (bus.lane_en_i[i]) begin
                w_emit_vec[i*WO +: WO] = w_sum[i];
            end
        end
    end

    // Accumulator storage write; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (w_beat) begin
            r_acc[r_addr] <= w_sum_vec;
        end
    end

    // FIFO storage write; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_fifo[r_wptr] <= w_emit_vec;
        end
    end

    // Address counter, FIFO pointers/occupancy and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_tile_done <= 1'b0;
        end else if (bus.clear_i) begin
            r_addr      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            r_tile_done <= w_push && w_last_addr;
            if (w_beat) begin
                r_addr <= w_last_addr ? '0 : r_addr + 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_push_ok) begin
                r_wptr <= (r_wptr == FW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == FW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign bus.oup_valid_o = (r_count != '0);
    assign bus.oup_data_o  = (r_count != '0) ? r_fifo[r_rptr] : '0;
    assign bus.tile_done_o = r_tile_done;
    assign bus.overflow_o  = r_overflow;

endmodule

// File: tb/tb_ita_tile_accumulator.sv
// Testbench for ita_tile_accumulator: directed tile scenarios plus a random
// phase, all compared cycle by cycle against a lane-level arithmetic model.
module tb_ita_tile_accumulator;
    localparam int N     = 16;
    localparam int M     = 64;
    localparam int WO    = 26;
    localparam int FD    = 4;
    localparam int DEPTH = M * M / N;
    localparam longint MAXV = (longint'(1) << (WO - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (WO - 1));

    logic clk;
    logic rst_n;

    ita_tile_accumulator_if #(.N(N), .WO(WO)) bus_if ();

    ita_tile_accumulator #(.N(N), .M(M), .WO(WO), .FIFO_DEPTH(FD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    // Reference state: accumulator contents as integers, expected FIFO contents.
    longint          acc_m [DEPTH][N];
    int              addr_m;
    logic [N*WO-1:0] q_m [$];
    bit              ovf_m;
    bit              td_m;

    int n_tests;
    int n_fail;
    int td_seen;
    int valid_seen;
    int pops_seen;

    task automatic check(input string tag, input logic [N*WO-1:0] obs, input logic [N*WO-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint rand_val();
        logic signed [WO-1:0] r;
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 2000)) - 1000;
            1: return MAXV - longint'($urandom_range(0, 300));
            2: return MINV + longint'($urandom_range(0, 300));
            default: begin
                r = WO'($urandom);
                return longint'(r);
            end
        endcase
    endfunction

    task automatic set_lane(input int i, input longint v);
        bus_if.psum_i[i*WO +: WO] = WO'(v);
    endtask

    task automatic fill_const(input longint v);
        for (int i = 0; i < N; i++) set_lane(i, v);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) set_lane(i, rand_val());
    endtask

    // Apply the behavioural rules for one clock edge to the reference state.
    task automatic model_step();
        bit pop;
        logic [N*WO-1:0] ov;
        longint b;
        longint s;
        pop = (q_m.size() != 0) && bus_if.oup_ready_i;
        if (bus_if.clear_i) begin
            q_m.delete();
            addr_m = 0;
            ovf_m  = 0;
            td_m   = 0;
            return;
        end
        td_m = 0;
        if (pop) void'(q_m.pop_front());
        if (bus_if.calc_en_i) begin
            ov = '0;
            for (int i = 0; i < N; i++) begin
                if (bus_if.first_inner_tile_i) b = 0;
                else b = acc_m[addr_m][i];
                s = clamp(b + longint'($signed(bus_if.psum_i[i*WO +: WO])));
                acc_m[addr_m][i] = s;
                if (bus_if.lane_en_i[i]) ov[i*WO +: WO] = WO'(s);
            end
            if (bus_if.last_inner_tile_i) begin
                if (q_m.size() < FD) q_m.push_back(ov);
                else ovf_m = 1;
                td_m = (addr_m == DEPTH - 1);
            end
            addr_m = (addr_m + 1) % DEPTH;
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model, move past the edge.
    task automatic cycle();
        logic [N*WO-1:0] e;
        @(negedge clk);
        e = (q_m.size() != 0) ? q_m[0] : '0;
        check("valid", bus_if.oup_valid_o, q_m.size() != 0);
        check("data", bus_if.oup_data_o, e);
        check("overflow", bus_if.overflow_o, ovf_m);
        check("tile_done", bus_if.tile_done_o, td_m);
        if (bus_if.tile_done_o) td_seen++;
        if (bus_if.oup_valid_o) valid_seen++;
        if (bus_if.oup_valid_o && bus_if.oup_ready_i) pops_seen++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit f, input bit l, input logic [N-1:0] en);
        bus_if.calc_en_i          = 1'b1;
        bus_if.first_inner_tile_i = f;
        bus_if.last_inner_tile_i  = l;
        bus_if.lane_en_i          = en;
        cycle();
        bus_if.calc_en_i          = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_if.calc_en_i = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        bus_if.calc_en_i = 1'b0;
        bus_if.clear_i   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", bus_if.oup_valid_o, 1'b0);
        check("rst_data", bus_if.oup_data_o, '0);
        check("rst_overflow", bus_if.overflow_o, 1'b0);
        check("rst_tile_done", bus_if.tile_done_o, 1'b0);
        q_m.delete();
        addr_m = 0;
        ovf_m  = 0;
        td_m   = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 0;
        rst_n = 1;
        n_tests = 0;
        n_fail = 0;
        bus_if.clear_i            = 0;
        bus_if.calc_en_i          = 0;
        bus_if.first_inner_tile_i = 0;
        bus_if.last_inner_tile_i  = 0;
        bus_if.lane_en_i          = '1;
        bus_if.psum_i             = '0;
        bus_if.oup_ready_i        = 1;
        #2;
        do_reset();

        // Single inner tile: every lane carries its own index.
        td_seen = 0;
        for (int b = 0; b < DEPTH; b++) begin
            for (int i = 0; i < N; i++) set_lane(i, i);
            beat(1, 1, '1);
        end
        idle(3);
        check("single_tile_done_pulses", td_seen, 1);

        // Three inner tiles of +5: nothing emitted until the last pass.
        valid_seen = 0;
        td_seen = 0;
        fill_const(5);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < DEPTH; b++) beat(p == 0, p == 2, '1);
            if (p == 1) check("no_valid_first_two_passes", valid_seen, 0);
        end
        idle(3);
        check("three_tile_outputs", valid_seen, DEPTH);
        check("three_tile_done_pulses", td_seen, 1);

        // Saturation: even lanes near max, odd lanes near min.
        for (int b = 0; b < DEPTH; b++) begin
            for (int i = 0; i < N; i++) set_lane(i, (i % 2 == 0) ? MAXV - 9 : MINV + 10);
            beat(1, 0, '1);
        end
        for (int b = 0; b < DEPTH; b++) begin
            for (int i = 0; i < N; i++) set_lane(i, (i % 2 == 0) ? 100 : -100);
            beat(0, 1, '1);
        end
        idle(3);

        // Lane mask on the last pass.
        for (int b = 0; b < DEPTH; b++) begin
            fill_rand();
            beat(1, 0, '1);
        end
        for (int b = 0; b < DEPTH; b++) begin
            fill_rand();
            beat(0, 1, 16'h00FF);
        end
        idle(3);

        // Back-pressure: FD+1 emits into a stalled FIFO, then drain.
        bus_if.oup_ready_i = 0;
        for (int b = 0; b < FD + 1; b++) begin
            fill_rand();
            beat(1, 1, '1);
        end
        idle(1);
        check("overflow_sticky", bus_if.overflow_o, 1'b1);
        pops_seen = 0;
        bus_if.oup_ready_i = 1;
        idle(FD + 3);
        check("drain_count", pops_seen, FD);
        bus_if.clear_i = 1;
        cycle();
        bus_if.clear_i = 0;

        // Reset mid-tile, then clear at address 37 colliding with a beat.
        for (int b = 0; b < 10; b++) begin
            fill_rand();
            beat(0, 1, '1);
        end
        do_reset();
        for (int b = 0; b < 37; b++) begin
            fill_rand();
            beat(1, 0, '1);
        end
        bus_if.clear_i = 1;
        fill_rand();
        beat(0, 1, '1);
        bus_if.clear_i = 0;
        idle(1);
        check("clear_valid_low", bus_if.oup_valid_o, 1'b0);
        td_seen = 0;
        for (int b = 0; b < DEPTH; b++) begin
            fill_rand();
            beat(1, 0, '1);
        end
        for (int b = 0; b < DEPTH; b++) begin
            fill_rand();
            beat(0, 1, '1);
        end
        idle(3);
        check("after_clear_done_pulses", td_seen, 1);

        // Random phase: arbitrary beats, back-pressure and occasional clears.
        for (int c = 0; c < 800; c++) begin
            fill_rand();
            bus_if.calc_en_i          = ($urandom_range(0, 3) != 0);
            bus_if.first_inner_tile_i = $urandom_range(0, 1);
            bus_if.last_inner_tile_i  = $urandom_range(0, 1);
            bus_if.lane_en_i          = N'($urandom);
            bus_if.oup_ready_i        = ($urandom_range(0, 2) != 0);
            bus_if.clear_i            = ($urandom_range(0, 99) == 0);
            cycle();
        end
        bus_if.clear_i = 0;
        bus_if.oup_ready_i = 1;
        idle(FD + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
